alu_ctrl_seq: RTL and testbench

Multicycle stage sequencer and ALU control encoder for the rhythm-game CPU core. It accepts one 32-bit RV32I instruction through a valid/ready handshake and steps a 3-bit stage counter through fetch, decode, execute, memory and writeback. It drives the 4-bit ALU operation code and operand-select bits that the ALU samples when the counter reaches execute (2). It is the producer side of the ALU's `counter`/`Control` interface.

---
 rtl/alu_ctrl_seq.sv | 215 +++++++++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_seq.sv
// Multicycle stage sequencer and ALU control encoder (RV32I).
// Define ALU_CTRL_MULDIV_EN to decode MUL/DIV/REM on OP f7=0000001.
module alu_ctrl_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [XLEN-1:0] instr,
  input  logic            stall,
  output logic [2:0]      counter,
  output logic [3:0]      Control,
  output logic            alu_src_imm,
  output logic            illegal,
  output logic            done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEC  = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SLL  = 4'b0011;
  localparam logic [3:0] C_SLTU = 4'b0100;
  localparam logic [3:0] C_SLT  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_XOR  = 4'b0111;
  localparam logic [3:0] C_SRL  = 4'b1000;
  localparam logic [3:0] C_ILL  = 4'b1001;
  localparam logic [3:0] C_SRA  = 4'b1010;
`ifdef ALU_CTRL_MULDIV_EN
  localparam logic [3:0] C_REM  = 4'b1011;
  localparam logic [3:0] C_DIV  = 4'b1101;
  localparam logic [3:0] C_MUL  = 4'b1110;
`endif

  state_t state, state_nxt;

  // Only opcode, funct3 and funct7 matter to the ALU control encoding.
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       mem_q;
  logic [3:0] d_ctrl;
  logic       d_imm, d_ill, d_mem;
  logic       unused_bits;

  assign unused_bits = ^{instr[24:15], instr[11:7]};

  function automatic logic [3:0] f3_ctrl(input logic [2:0] f);
    logic [3:0] c;
    c = C_ADD;
    unique case (f)
      3'b000: c = C_ADD;
      3'b001: c = C_SLL;
      3'b010: c = C_SLT;
      3'b011: c = C_SLTU;
      3'b100: c = C_XOR;
      3'b101: c = C_SRL;
      3'b110: c = C_OR;
      3'b111: c = C_AND;
      default: c = C_ADD;
    endcase
    return c;
  endfunction

  always_comb begin
    d_ctrl = C_ILL;
    d_imm  = 1'b0;
    d_ill  = 1'b1;
    d_mem  = 1'b0;
    unique case (opc)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          d_ctrl = f3_ctrl(f3);
          d_ill  = 1'b0;
        end else if (f7 == F7_ALT) begin
          if (f3 == 3'b000) begin
            d_ctrl = C_SUB;
            d_ill  = 1'b0;
          end else if (f3 == 3'b101) begin
            d_ctrl = C_SRA;
            d_ill  = 1'b0;
          end
        end else if (f7 == F7_MD) begin
`ifdef ALU_CTRL_MULDIV_EN
          if (f3 == 3'b000) begin
            d_ctrl = C_MUL;
            d_ill  = 1'b0;
          end else if (f3 == 3'b100) begin
            d_ctrl = C_DIV;
            d_ill  = 1'b0;
          end else if (f3 == 3'b110) begin
            d_ctrl = C_REM;
            d_ill  = 1'b0;
          end
`else
          d_ill = 1'b1;
`endif
        end
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001) begin
          if (f7 == F7_BASE) begin
            d_ctrl = C_SLL;
            d_imm  = 1'b1;
            d_ill  = 1'b0;
          end
        end else if (f3 == 3'b101) begin
          if (f7 == F7_BASE || f7 == F7_ALT) begin
            d_ctrl = (f7 == F7_ALT) ? C_SRA : C_SRL;
            d_imm  = 1'b1;
            d_ill  = 1'b0;
          end
        end else begin
          d_ctrl = f3_ctrl(f3);
          d_imm  = 1'b1;
          d_ill  = 1'b0;
        end
      end
      OPC_LOAD, OPC_STORE: begin
        d_ctrl = C_ADD;
        d_imm  = 1'b1;
        d_ill  = 1'b0;
        d_mem  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        d_ctrl = C_ADD;
        d_imm  = 1'b1;
        d_ill  = 1'b0;
      end
      OPC_BRANCH: begin
        unique case (f3)
          3'b000, 3'b001: begin
            d_ctrl = C_SUB;
            d_ill  = 1'b0;
          end
          3'b100, 3'b101: begin
            d_ctrl = C_SLT;
            d_ill  = 1'b0;
          end
          3'b110, 3'b111: begin
            d_ctrl = C_SLTU;
            d_ill  = 1'b0;
          end
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (instr_valid) state_nxt = S_DEC;
      S_DEC:  state_nxt = d_ill ? S_WB : S_EXE;
      S_EXE:  state_nxt = mem_q ? S_MEM : S_WB;
      S_MEM:  if (!stall) state_nxt = S_WB;
      S_WB:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      opc         <= '0;
      f3          <= '0;
      f7          <= '0;
      mem_q       <= 1'b0;
      Control     <= C_ILL;
      alu_src_imm <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && instr_valid) begin
        opc <= instr[6:0];
        f3  <= instr[14:12];
        f7  <= instr[31:25];
      end
      if (state == S_DEC) begin
        Control     <= d_ctrl;
        alu_src_imm <= d_imm;
        illegal     <= d_ill;
        mem_q       <= d_mem;
      end
    end
  end

  assign counter     = state;
  assign instr_ready = (state == S_IDLE);
  assign done        = (state == S_WB);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: stimulus pushes expectations,
// a negedge monitor pops and checks them at every done pulse.
module tb_alu_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        stall = 1'b0;
  logic [2:0]  counter;
  logic [3:0]  Control;
  logic        alu_src_imm;
  logic        illegal;
  logic        done;

  alu_ctrl_seq #(.XLEN(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .stall(stall),
    .counter(counter),
    .Control(Control),
    .alu_src_imm(alu_src_imm),
    .illegal(illegal),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] ctrl;
    logic       imm;
    logic       ill;
    int         len;
    logic [23:0] seq;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, req);
  endtask

  function automatic exp_t mk(input string nm, input logic [3:0] c,
                              input logic im, input logic il,
                              input int ln, input logic [23:0] sq);
    exp_t e;
    e.name = nm; e.ctrl = c; e.imm = im; e.ill = il;
    e.len = ln; e.seq = sq;
    return e;
  endfunction

  task automatic rst_chk(input string tag);
    chk({tag, "_counter"}, 32'(counter), 0);
    chk({tag, "_ctrl"}, 32'(Control), 4'b1001);
    chk({tag, "_imm"}, 32'(alu_src_imm), 0);
    chk({tag, "_ill"}, 32'(illegal), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ready"}, 32'(instr_ready), 1);
  endtask

  // Called at posedge+2; returns at posedge+2 with counter back at 0.
  task automatic send(input logic [31:0] w, input int nst,
                      input logic noise, input logic hold,
                      input logic [31:0] nxt, input exp_t e);
    int n = 0;
    int k = 0;
    int ns = 0;
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #2; n++;
    end
    chk({e.name, "_accept"}, 32'(instr_ready), 1);
    sb.push_back(e);
    @(posedge clk); #2;
    if (hold) begin
      instr = nxt;
    end else begin
      instr_valid = 1'b0;
      instr = $urandom;
    end
    while (counter != 3'd4 && k < 40) begin
      if (counter == 3'd3) begin
        stall = (ns < nst);
        if (stall) ns++;
      end else begin
        stall = noise;
      end
      @(posedge clk); #2; k++;
    end
    chk({e.name, "_wb"}, 32'(counter), 4);
    stall = noise;
    @(posedge clk); #2;
    stall = 1'b0;
  endtask

  int         mon_len = 0;
  logic [23:0] mon_seq = '0;
  logic       after = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mon_len = 0;
      mon_seq = '0;
      after = 1'b0;
    end else begin
      if (after) begin
        chk("post_done_counter", 32'(counter), 0);
        chk("post_done_done", 32'(done), 0);
        after = 1'b0;
      end
      if (counter != 3'd0) begin
        mon_seq = {mon_seq[20:0], counter};
        mon_len++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("extra_done", 32'(sb.size()), 1);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_ctrl"}, 32'(Control), 32'(e.ctrl));
          chk({e.name, "_ill"}, 32'(illegal), 32'(e.ill));
          if (!e.ill) chk({e.name, "_imm"}, 32'(alu_src_imm), 32'(e.imm));
          chk({e.name, "_len"}, 32'(mon_len), 32'(e.len));
          chk({e.name, "_seq"}, 32'(mon_seq), 32'(e.seq));
        end
        after = 1'b1;
        mon_len = 0;
        mon_seq = '0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  localparam logic [23:0] SQ_ALU = 24'o124;
  localparam logic [23:0] SQ_ILL = 24'o14;

  initial begin
    #1 rst_n = 1'b0;
    #1 rst_chk("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    send(32'h002081B3, 0, 1'b1, 1'b0, 0,
         mk("add", 4'b0010, 1'b0, 1'b0, 3, SQ_ALU));
    send(32'h0000A183, 2, 1'b0, 1'b0, 0,
         mk("lw", 4'b0010, 1'b1, 1'b0, 6, 24'o123334));
    send(32'h0020A023, 0, 1'b1, 1'b0, 0,
         mk("sw", 4'b0010, 1'b1, 1'b0, 4, 24'o1234));
    send(32'h4020D193, 0, 1'b0, 1'b0, 0,
         mk("srai", 4'b1010, 1'b1, 1'b0, 3, SQ_ALU));
    send(32'h0020E063, 0, 1'b0, 1'b0, 0,
         mk("bltu", 4'b0100, 1'b0, 1'b0, 3, SQ_ALU));
`ifdef ALU_CTRL_MULDIV_EN
    send(32'h022081B3, 0, 1'b0, 1'b0, 0,
         mk("mul", 4'b1110, 1'b0, 1'b0, 3, SQ_ALU));
`else
    send(32'h022081B3, 0, 1'b0, 1'b0, 0,
         mk("mul", 4'b1001, 1'b0, 1'b1, 2, SQ_ILL));
`endif
    send(32'h00508193, 0, 1'b0, 1'b0, 0,
         mk("addi", 4'b0010, 1'b1, 1'b0, 3, SQ_ALU));
    send(32'h402081B3, 0, 1'b0, 1'b0, 0,
         mk("sub", 4'b0110, 1'b0, 1'b0, 3, SQ_ALU));
    send(32'h0020A063, 0, 1'b1, 1'b0, 0,
         mk("br_f3_010", 4'b1001, 1'b0, 1'b1, 2, SQ_ILL));
    send(32'h402091B3, 0, 1'b0, 1'b0, 0,
         mk("op_alt_sll", 4'b1001, 1'b0, 1'b1, 2, SQ_ILL));
    send(32'h40209193, 0, 1'b0, 1'b0, 0,
         mk("slli_bad", 4'b1001, 1'b0, 1'b1, 2, SQ_ILL));
    send(32'hFFFFFFFF, 0, 1'b0, 1'b0, 0,
         mk("bad_opc", 4'b1001, 1'b0, 1'b1, 2, SQ_ILL));
    send(32'h0020F0B3, 0, 1'b0, 1'b0, 0,
         mk("and", 4'b0000, 1'b0, 1'b0, 3, SQ_ALU));

    // Reset while the counter sits in execute.
    instr_valid = 1'b1;
    instr = 32'h002081B3;
    @(posedge clk); #2;
    instr_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_counter", 32'(counter), 2);
    rst_n = 1'b0;
    #1 rst_chk("mid_rst");
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Valid held high across two instructions.
    send(32'h0020E1B3, 0, 1'b0, 1'b1, 32'h0020F1B3,
         mk("or_b2b", 4'b0001, 1'b0, 1'b0, 3, SQ_ALU));
    send(32'h0020F1B3, 0, 1'b0, 1'b0, 0,
         mk("and_b2b", 4'b0000, 1'b0, 1'b0, 3, SQ_ALU));

    repeat (4) @(posedge clk);
    #2 chk("sb_empty", 32'(sb.size()), 0);
    chk("idle_counter", 32'(counter), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
